// File: rtl/change_disp_pkg.sv
// Shared types and helpers for the change dispenser.
package change_disp_pkg;

  // Width of the nickel code coming from the vending controller
  localparam int unsigned CHANGE_W = 3;
  localparam int unsigned DEFAULT_MAX_CHANGE = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSoda,
    StEject,
    StWaitAck,
    StFault
  } state_e;

  // Limit an incoming nickel count to the largest amount the chute may pay out
  function automatic logic [CHANGE_W-1:0] clamp_change(input logic [CHANGE_W-1:0] change,
                                                       input int unsigned max_change);
    if (32'(change) > max_change) begin
      return CHANGE_W'(max_change);
    end
    return change;
  endfunction

endpackage

// File: rtl/change_fifo.sv
// Synchronous FIFO for queued vend requests. First-word-fall-through read.
// Push while full is accepted when a pop happens in the same cycle.
module change_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  // Accept/advance decisions
  always_comb begin
    full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    empty_o = (count_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rdata_o = mem_q[rd_ptr_q];
  end

  // Storage array, no reset needed since occupancy is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Actuator stage after the vending controller: queues vends, pulses the soda motor, then
// ejects owed nickels one by one, each confirmed by the chute sensor with a timeout.
// Build option: define CHANGE_DISP_RETRY_EN to re-eject a nickel once after its first timeout.
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_CHANGE  = DEFAULT_MAX_CHANGE,
  parameter int unsigned SODA_PULSE  = 8,
  parameter int unsigned EJECT_PULSE = 4,
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_vend,
  input  logic [CHANGE_W-1:0] i_change,
  input  logic                i_coin_sense,
  input  logic                i_fault_clr,
  output logic                o_soda_motor,
  output logic                o_nickel_eject,
  output logic                o_nickel_done,
  output logic                o_busy,
  output logic                o_full,
  output logic                o_drop,
  output logic                o_fault
);

  localparam int unsigned REM_W     = $clog2(MAX_CHANGE + 1);
  localparam int unsigned PULSE_MAX = (SODA_PULSE > EJECT_PULSE) ? SODA_PULSE : EJECT_PULSE;
  localparam int unsigned TIMER_MAX = (PULSE_MAX > ACK_TIMEOUT) ? PULSE_MAX : ACK_TIMEOUT;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0] SODA_LAST  = TIMER_W'(SODA_PULSE - 1);
  localparam logic [TIMER_W-1:0] EJECT_LAST = TIMER_W'(EJECT_PULSE - 1);
  localparam logic [TIMER_W-1:0] ACK_LAST   = TIMER_W'(ACK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
  logic                 ack_seen_q, ack_seen_d;
  logic                 retry_q, retry_d;
  logic                 done_q, done_d;
  logic                 drop_q;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CHANGE_W-1:0]  fifo_wdata, fifo_rdata;

  change_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHANGE_W)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Request intake: the FIFO itself refuses a push when full with no pop
  always_comb begin
    fifo_push  = i_vend;
    fifo_wdata = clamp_change(i_change, MAX_CHANGE);
    timer_inc  = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
  end

  // Next-state logic for the vend sequencer
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    timer_d    = timer_inc;
    ack_seen_d = ack_seen_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d    = '0;
        ack_seen_d = 1'b0;
        retry_d    = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rem_d    = REM_W'(fifo_rdata);
          state_d  = StSoda;
        end
      end

      StSoda: begin
        ack_seen_d = 1'b0;
        if (timer_q == SODA_LAST) begin
          timer_d = '0;
          state_d = (rem_q == '0) ? StIdle : StEject;
        end
      end

      StEject: begin
        // A fast sensor can report the coin before the solenoid pulse ends
        if (i_coin_sense) ack_seen_d = 1'b1;
        if (timer_q == EJECT_LAST) begin
          timer_d = '0;
          state_d = StWaitAck;
        end
      end

      StWaitAck: begin
        if (ack_seen_q || i_coin_sense) begin
          done_d     = 1'b1;
          rem_d      = rem_q - REM_W'(1);
          ack_seen_d = 1'b0;
          retry_d    = 1'b0;
          timer_d    = '0;
          state_d    = (rem_q == REM_W'(1)) ? StIdle : StEject;
        end else if (timer_q == ACK_LAST) begin
          timer_d = '0;
`ifdef CHANGE_DISP_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = StEject;
          end else begin
            state_d = StFault;
          end
`else
          state_d = StFault;
`endif
        end
      end

      StFault: begin
        timer_d    = '0;
        ack_seen_d = 1'b0;
        if (i_fault_clr) begin
          // Abandon whatever is still owed on the stuck vend
          rem_d   = '0;
          retry_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      timer_q    <= '0;
      ack_seen_q <= 1'b0;
      retry_q    <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      timer_q    <= timer_d;
      ack_seen_q <= ack_seen_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      drop_q     <= i_vend && fifo_full && !fifo_pop;
    end
  end

  // Drives decoded from the registered state
  always_comb begin
    o_soda_motor   = (state_q == StSoda);
    o_nickel_eject = (state_q == StEject);
    o_fault        = (state_q == StFault);
    o_nickel_done  = done_q;
    o_drop         = drop_q;
    o_full         = fifo_full;
    o_busy         = (state_q != StIdle) || !fifo_empty;
  end

endmodule
